// File: rtl/uart_pkg.sv
// Shared register map, bit positions and helpers for the UART receive-path controller.
package uart_pkg;

   localparam logic [1:0] UART_REG_DATA   = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;
   localparam logic [1:0] UART_REG_CTRL   = 2'd2;
   localparam logic [1:0] UART_REG_COUNT  = 2'd3;

   localparam int unsigned STAT_NOTEMPTY = 0;
   localparam int unsigned STAT_FULL     = 1;
   localparam int unsigned STAT_OVR      = 2;

   localparam int unsigned CTRL_IRQEN = 0;
   localparam int unsigned CTRL_FLUSH = 1;

   // COUNT is an 8-bit register while a 256-deep FIFO can hold 256 entries.
   function automatic logic [7:0] sat_u8(input logic [8:0] value);
      return (value > 9'd255) ? 8'hFF : value[7:0];
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver strobe/data plus CPU register-bus signals of the UART receive controller.
interface uart_rx_ctrl_if;

   logic       i_rxValid;
   logic [7:0] i_rxData;
   logic       i_sel;
   logic       i_read;
   logic       i_write;
   logic [1:0] i_addr;
   logic [7:0] i_wdata;
   logic [7:0] o_rdata;
   logic       o_irq;

   modport master (
      output i_rxValid,
      output i_rxData,
      output i_sel,
      output i_read,
      output i_write,
      output i_addr,
      output i_wdata,
      input  o_rdata,
      input  o_irq
   );

   modport slave (
      input  i_rxValid,
      input  i_rxData,
      input  i_sel,
      input  i_read,
      input  i_write,
      input  i_addr,
      input  i_wdata,
      output o_rdata,
      output o_irq
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Single-clock byte FIFO with push, pop and flush; the head is visible combinationally.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [7:0]               wdata,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign count = count_q;
   assign head  = mem[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (PTR_W + 1)'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - (PTR_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-path host controller: captures received bytes into a FIFO and exposes
// them through a four-register bus slave with overrun tracking and an interrupt.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic          i_clk,
   input  logic          i_resetn,
   uart_rx_ctrl_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic             rx_valid_prev_q;
   logic             ovr_q, ovr_d;
   logic             irq_en_q, irq_en_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             irq_q, irq_d;

   logic             push;
   logic             acc_rd;
   logic             acc_wr;
   logic             data_rd;
   logic             flush;
   logic             ovr_set;
   logic             ovr_clr;

   logic [7:0]       head;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;
   logic [7:0]       status;
   logic [7:0]       ctrl;
   logic             unused_wdata;

   assign push    = bus.i_rxValid & ~rx_valid_prev_q;
   assign acc_rd  = bus.i_sel & bus.i_read;
   assign acc_wr  = bus.i_sel & bus.i_write;
   assign data_rd = acc_rd & (bus.i_addr == UART_REG_DATA);
   assign flush   = acc_wr & (bus.i_addr == UART_REG_CTRL) & bus.i_wdata[CTRL_FLUSH];
   assign ovr_clr = acc_wr & (bus.i_addr == UART_REG_STATUS) & bus.i_wdata[STAT_OVR];

   // Drop on full only when no pop frees a slot; a flushed push never counts as overrun.
   assign ovr_set = push & full & ~(data_rd & ~empty) & ~flush;

   assign unused_wdata = ^bus.i_wdata[7:3];

   uart_rx_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_resetn),
      .push  (push),
      .pop   (data_rd),
      .flush (flush),
      .wdata (bus.i_rxData),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      status                = '0;
      status[STAT_NOTEMPTY] = ~empty;
      status[STAT_FULL]     = full;
      status[STAT_OVR]      = ovr_q;
      ctrl                  = '0;
      ctrl[CTRL_IRQEN]      = irq_en_q;
   end

   always_comb begin
      ovr_d = ovr_q;
      if (flush) begin
         ovr_d = 1'b0;
      end else if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end
   end

   always_comb begin
      irq_en_d = irq_en_q;
      if (acc_wr && (bus.i_addr == UART_REG_CTRL)) begin
         irq_en_d = bus.i_wdata[CTRL_IRQEN];
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (acc_rd) begin
         case (bus.i_addr)
            UART_REG_DATA:   rdata_d = empty ? 8'h00 : head;
            UART_REG_STATUS: rdata_d = status;
            UART_REG_CTRL:   rdata_d = ctrl;
            default:         rdata_d = sat_u8(9'(count));
         endcase
      end
   end

   // Built from the registered state, so irq trails a state change by one cycle.
   assign irq_d = irq_en_q & (~empty | ovr_q);

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         rx_valid_prev_q <= 1'b0;
         ovr_q           <= 1'b0;
         irq_en_q        <= 1'b0;
         rdata_q         <= 8'h00;
         irq_q           <= 1'b0;
      end else begin
         rx_valid_prev_q <= bus.i_rxValid;
         ovr_q           <= ovr_d;
         irq_en_q        <= irq_en_d;
         rdata_q         <= rdata_d;
         irq_q           <= irq_d;
      end
   end

   assign bus.o_rdata = rdata_q;
   assign bus.o_irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a vector table for the basic flow plus
// hand-written sequences for overrun, full push/pop, flush and reset.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   typedef enum logic [1:0] {OpWr, OpRd, OpPush, OpIrq} op_e;

   typedef struct {
      op_e        op;
      logic [1:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(
      .DEPTH(16)
   ) dut (
      .i_clk    (clk),
      .i_resetn (resetn),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.i_sel   = 1'b0;
      bus.i_read  = 1'b0;
      bus.i_write = 1'b0;
      bus.i_addr  = 2'd0;
      bus.i_wdata = 8'h00;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
      bus.i_sel  = 1'b1;
      bus.i_read = 1'b1;
      bus.i_addr = addr;
      cycle();
      data = bus.o_rdata;
      bus_idle();
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
      bus.i_sel   = 1'b1;
      bus.i_write = 1'b1;
      bus.i_addr  = addr;
      bus.i_wdata = data;
      cycle();
      bus_idle();
   endtask

   task automatic push_byte(input logic [7:0] data);
      bus.i_rxValid = 1'b1;
      bus.i_rxData  = data;
      cycle();
      bus.i_rxValid = 1'b0;
      cycle();
   endtask

   task automatic read_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
      logic [7:0] d;
      bus_read(addr, d);
      check(name, d, exp);
   endtask

   vec_t vecs[$];

   initial begin
      logic [7:0] d;
      checks        = 0;
      failures      = 0;
      resetn        = 1'b0;
      bus.i_rxValid = 1'b0;
      bus.i_rxData  = 8'h00;
      bus_idle();

      #23;
      check("reset_rdata", bus.o_rdata, 8'h00);
      check("reset_irq", {7'd0, bus.o_irq}, 8'h00);
      resetn = 1'b1;
      cycle();

      // Basic FIFO and irq flow
      vecs.push_back('{OpWr,   UART_REG_CTRL,   8'h01, 8'h00});
      vecs.push_back('{OpPush, UART_REG_DATA,   8'h41, 8'h00});
      vecs.push_back('{OpPush, UART_REG_DATA,   8'h42, 8'h00});
      vecs.push_back('{OpPush, UART_REG_DATA,   8'h43, 8'h00});
      vecs.push_back('{OpRd,   UART_REG_COUNT,  8'h00, 8'h03});
      vecs.push_back('{OpRd,   UART_REG_STATUS, 8'h00, 8'h01});
      vecs.push_back('{OpRd,   UART_REG_CTRL,   8'h00, 8'h01});
      vecs.push_back('{OpIrq,  UART_REG_DATA,   8'h00, 8'h01});
      vecs.push_back('{OpRd,   UART_REG_DATA,   8'h00, 8'h41});
      vecs.push_back('{OpRd,   UART_REG_DATA,   8'h00, 8'h42});
      vecs.push_back('{OpRd,   UART_REG_DATA,   8'h00, 8'h43});
      vecs.push_back('{OpRd,   UART_REG_STATUS, 8'h00, 8'h00});
      vecs.push_back('{OpIrq,  UART_REG_DATA,   8'h00, 8'h00});
      vecs.push_back('{OpRd,   UART_REG_DATA,   8'h00, 8'h00});
      vecs.push_back('{OpRd,   UART_REG_COUNT,  8'h00, 8'h00});
      vecs.push_back('{OpWr,   UART_REG_DATA,   8'h99, 8'h00});
      vecs.push_back('{OpRd,   UART_REG_COUNT,  8'h00, 8'h00});

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OpWr:   bus_write(vecs[i].addr, vecs[i].data);
            OpPush: push_byte(vecs[i].data);
            OpRd:   read_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
            default: check($sformatf("vec%0d_irq", i), {7'd0, bus.o_irq}, vecs[i].exp);
         endcase
      end

      // Held strobe counts as one byte
      bus.i_rxValid = 1'b1;
      bus.i_rxData  = 8'h55;
      repeat (5) cycle();
      bus.i_rxValid = 1'b0;
      cycle();
      read_check("held_count", UART_REG_COUNT, 8'h01);
      read_check("held_data", UART_REG_DATA, 8'h55);

      // Overrun: 17 pushes into 16 entries
      for (int i = 0; i < 17; i++) push_byte(8'(i));
      read_check("ovr_status", UART_REG_STATUS, 8'h07);
      read_check("ovr_count", UART_REG_COUNT, 8'h10);
      for (int i = 0; i < 16; i++) read_check($sformatf("ovr_data%0d", i), UART_REG_DATA, 8'(i));
      read_check("ovr_sticky", UART_REG_STATUS, 8'h04);
      check("ovr_irq", {7'd0, bus.o_irq}, 8'h01);
      bus_write(UART_REG_STATUS, 8'h04);
      read_check("ovr_cleared", UART_REG_STATUS, 8'h00);
      check("ovr_irq_clear", {7'd0, bus.o_irq}, 8'h00);

      // Push and pop together while full
      for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
      read_check("full_status", UART_REG_STATUS, 8'h03);
      bus.i_rxValid = 1'b1;
      bus.i_rxData  = 8'hAA;
      bus_read(UART_REG_DATA, d);
      check("pp_head", d, 8'h80);
      bus.i_rxValid = 1'b0;
      cycle();
      read_check("pp_status", UART_REG_STATUS, 8'h03);
      read_check("pp_count", UART_REG_COUNT, 8'h10);
      for (int i = 1; i < 16; i++) read_check("pp_data", UART_REG_DATA, 8'h80 + 8'(i));
      read_check("pp_last", UART_REG_DATA, 8'hAA);
      read_check("pp_empty", UART_REG_STATUS, 8'h00);

      // Overrun clear coincident with a new overrun: set wins
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      bus.i_rxValid = 1'b1;
      bus.i_rxData  = 8'hEE;
      bus_write(UART_REG_STATUS, 8'h04);
      bus.i_rxValid = 1'b0;
      cycle();
      read_check("setwins_status", UART_REG_STATUS, 8'h07);
      bus_write(UART_REG_CTRL, 8'h03);
      read_check("setwins_flushed", UART_REG_COUNT, 8'h00);

      // Flush with 4 queued and overrun set
      for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
      for (int i = 0; i < 12; i++) bus_read(UART_REG_DATA, d);
      read_check("pre_flush_count", UART_REG_COUNT, 8'h04);
      read_check("pre_flush_status", UART_REG_STATUS, 8'h05);
      bus_write(UART_REG_CTRL, 8'h03);
      read_check("flush_count", UART_REG_COUNT, 8'h00);
      read_check("flush_status", UART_REG_STATUS, 8'h00);
      read_check("flush_ctrl", UART_REG_CTRL, 8'h01);

      // Flush coincident with push drops the byte
      bus.i_rxValid = 1'b1;
      bus.i_rxData  = 8'h77;
      bus_write(UART_REG_CTRL, 8'h03);
      bus.i_rxValid = 1'b0;
      cycle();
      read_check("flushpush_count", UART_REG_COUNT, 8'h00);
      read_check("flushpush_status", UART_REG_STATUS, 8'h00);

      // Asynchronous reset mid-stream
      push_byte(8'h5A);
      read_check("rst_pre_data", UART_REG_DATA, 8'h5A);
      push_byte(8'h11);
      push_byte(8'h22);
      check("rst_pre_irq", {7'd0, bus.o_irq}, 8'h01);
      #1;
      resetn = 1'b0;
      #1;
      check("rst_async_irq", {7'd0, bus.o_irq}, 8'h00);
      check("rst_async_rdata", bus.o_rdata, 8'h00);
      #1;
      resetn = 1'b1;
      cycle();
      read_check("rst_status", UART_REG_STATUS, 8'h00);
      read_check("rst_data", UART_REG_DATA, 8'h00);
      read_check("rst_ctrl", UART_REG_CTRL, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
